// File: rtl/dbg_reg_acc_ctrl.sv
// dbg_reg_acc_ctrl: sequences debug abstract register commands onto the decode-stage GPR/CSR port.
// Rev 1.0
`default_nettype none
module dbg_reg_acc_ctrl #(
  parameter int CSR_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        halted,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_regno,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_err,
  output logic        busy,
  output logic [11:0] dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        dbg_gpr_rd,
  output logic        dbg_gpr_wr,
  output logic        dbg_csr_rd,
  output logic        dbg_csr_wr,
  input  logic [31:0] dbg_gpr_out,
  input  logic [31:0] dbg_csr_out,
  input  logic        dbg_csr_ill
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] c_ERR_OK   = 3'd0;
  localparam logic [2:0] c_ERR_REG  = 3'd2;
  localparam logic [2:0] c_ERR_EXC  = 3'd3;
  localparam logic [2:0] c_ERR_HALT = 3'd4;

  state_t             r_state, w_state_d;
  logic               r_cmd_ready;
  logic               r_wr, r_is_gpr;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rdata;
  logic [2:0]         r_err;
  logic [11:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_strb;   // {gpr_rd, gpr_wr, csr_rd, csr_wr}

  logic w_accept, w_is_csr, w_is_gpr, w_csr_done;

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_is_csr = (cmd_regno[15:12] == 4'h0);
  assign w_is_gpr = (cmd_regno[15:5] == 11'h080);
  assign w_csr_done = (r_state == S_WAIT) && (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!halted || !(w_is_csr || w_is_gpr)) w_state_d = S_RESP;
          else                                    w_state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (!halted || r_is_gpr || (CSR_LAT == 0)) w_state_d = S_RESP;
        else                                       w_state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!halted || (r_cnt == '0)) w_state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cmd_ready <= 1'b0;
      r_wr        <= 1'b0;
      r_is_gpr    <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
    end else begin
      r_cmd_ready <= (w_state_d == S_IDLE);
      r_strb      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr     <= cmd_wr;
            r_is_gpr <= w_is_gpr;
            r_rdata  <= '0;
            if (!halted) begin
              r_err <= c_ERR_HALT;
            end else if (!(w_is_csr || w_is_gpr)) begin
              r_err <= c_ERR_REG;
            end else begin
              r_err   <= c_ERR_OK;
              r_addr  <= w_is_gpr ? {7'b0, cmd_regno[4:0]} : cmd_regno[11:0];
              r_wdata <= cmd_wdata;
              r_strb  <= {w_is_gpr & ~cmd_wr, w_is_gpr & cmd_wr,
                          w_is_csr & ~cmd_wr, w_is_csr & cmd_wr};
            end
          end
        end
        S_ACC: begin
          if (!halted) begin
            r_err   <= c_ERR_HALT;
            r_rdata <= '0;
          end else if (r_is_gpr) begin
            if (!r_wr) r_rdata <= dbg_gpr_out;
          end else if (CSR_LAT == 0) begin
            r_err   <= dbg_csr_ill ? c_ERR_EXC : c_ERR_OK;
            r_rdata <= (dbg_csr_ill || r_wr) ? 32'h0 : dbg_csr_out;
          end else begin
            r_cnt <= CNT_W'(CSR_LAT - 1);
          end
        end
        S_WAIT: begin
          // Halt loss takes priority over a CSR exception reported at the same time.
          if (!halted) begin
            r_err   <= c_ERR_HALT;
            r_rdata <= '0;
          end else if (w_csr_done) begin
            r_err   <= dbg_csr_ill ? c_ERR_EXC : c_ERR_OK;
            r_rdata <= (dbg_csr_ill || r_wr) ? 32'h0 : dbg_csr_out;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign dbg_addr   = r_addr;
  assign dbg_wdata  = r_wdata;
  assign dbg_gpr_rd = r_strb[3];
  assign dbg_gpr_wr = r_strb[2];
  assign dbg_csr_rd = r_strb[1];
  assign dbg_csr_wr = r_strb[0];

endmodule
`default_nettype wire

// File: doc/dbg_reg_acc_ctrl.md
Name: dbg_reg_acc_ctrl

Overview:
- Sequences debug-module abstract register commands onto the decode stage's debug GPR/CSR access port.
- Accepts one command at a time over a valid/ready handshake and checks that the core is halted and the register number is supported.
- Issues one single-cycle access strobe, waits out the CSR read latency, then returns read data and an error code over a valid/ready response channel.

Parameters:
- CSR_LAT, 2, cycles from the CSR strobe cycle to valid dbg_csr_out/dbg_csr_ill (0..15).
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > CSR_LAT.

Ports:
- clk  input  1  core clock
- rstn  input  1  synchronous active-low reset
- halted  input  1  core is in debug halt
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_wr  input  1  1 = write, 0 = read
- cmd_regno  input  16  0x0000-0x0FFF = CSR, 0x1000-0x101F = GPR x0-x31
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  3  0 = ok, 2 = unsupported regno, 3 = CSR exception, 4 = not halted
- busy  output  1  high in any state other than IDLE
- dbg_addr  output  12  access address to decode stage (CSR number, or GPR index in [4:0])
- dbg_wdata  output  32  access write data
- dbg_gpr_rd  output  1  GPR read strobe
- dbg_gpr_wr  output  1  GPR write strobe
- dbg_csr_rd  output  1  CSR read strobe
- dbg_csr_wr  output  1  CSR write strobe
- dbg_gpr_out  input  32  GPR read data, valid in the strobe cycle
- dbg_csr_out  input  32  CSR read data, valid CSR_LAT cycles after the strobe
- dbg_csr_ill  input  1  CSR access illegal; sampled with dbg_csr_out

Behaviour:
- Reset (rstn low at a clk edge): state = IDLE; all outputs and latched registers = 0. cmd_ready rises to 1 in the first cycle after reset releases.
- Reset mid-operation aborts unconditionally: no response is produced, and any pending strobe is dropped.
- States: IDLE, ACC, WAIT, RESP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch cmd_wr, cmd_regno and cmd_wdata, then check in this priority order:
  - !halted: rsp_err = 4, go to RESP.
  - regno is neither CSR (regno[15:12] = 0) nor GPR (regno[15:5] = 0x080): rsp_err = 2, go to RESP.
  - Otherwise: load dbg_addr (CSR: regno[11:0]; GPR: {7'b0, regno[4:0]}) and dbg_wdata, go to ACC.
- cmd_ready = 0 in every state other than IDLE. No command is accepted during RESP.
- ACC (exactly 1 cycle): exactly one of the four strobes is high, selected by cmd_wr and the GPR/CSR class.
  - GPR read: rsp_rdata <= dbg_gpr_out at the end of ACC.
  - GPR write: no data captured.
  - Both GPR cases go to RESP with rsp_err = 0.
  - CSR with CSR_LAT = 0: sample dbg_csr_out/dbg_csr_ill at the end of ACC, go to RESP.
  - CSR with CSR_LAT > 0: counter <= CSR_LAT - 1, go to WAIT.
- WAIT: strobes low; dbg_addr/dbg_wdata held stable. Counter decrements each cycle. At counter = 0:
  - dbg_csr_ill = 1: rsp_err = 3, rsp_rdata = 0.
  - Else: rsp_err = 0; rsp_rdata = dbg_csr_out for reads, 0 for writes.
  - Go to RESP.
- Halt loss: if halted falls while in ACC or WAIT, the strobe (if in ACC) is still issued. The next state is RESP with rsp_err = 4 and rsp_rdata = 0, which overrides a CSR exception.
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err stable until rsp_valid & rsp_ready. On that handshake go to IDLE; rsp_valid falls the next cycle.
- Back-to-back throughput: a new command is accepted no earlier than the cycle after the response handshake.
- Writes to x0 are issued normally; the register file ignores them. A read of x0 returns 0.
- Strobes are registered outputs. They are never high outside ACC, and never more than one at a time.
- Latency from command accept to rsp_valid:
  - GPR: 2 cycles.
  - CSR: 2 + CSR_LAT cycles.
  - Error detected in IDLE: 1 cycle.

Test Plan:
- Halted, GPR read, regno 0x1005, dbg_gpr_out = 0xDEADBEEF -> dbg_gpr_rd pulses 1 cycle with dbg_addr = 0x005. rsp_valid 2 cycles after accept, with rdata 0xDEADBEEF and err 0.
- Halted, CSR write, regno 0x0300, wdata 0x00001888, CSR_LAT = 2 -> dbg_csr_wr pulses 1 cycle with dbg_addr = 0x300 and dbg_wdata = 0x1888. rsp_valid 4 cycles after accept, err 0.
- Halted, CSR read, regno 0x07B0, dbg_csr_ill = 1 at the sample cycle -> err 3, rdata 0.
- Not halted, any command -> no strobe; rsp_valid 1 cycle after accept with err 4. Also: regno 0x1020 while halted -> no strobe, err 2.
- Response backpressure: hold rsp_ready = 0 for 5 cycles with a second cmd_valid pending -> rsp stable and cmd_ready = 0 throughout. Second command accepted the cycle after the handshake.
- Abort cases: halted falls during WAIT -> err 4. Separately, rstn low during WAIT -> next cycle all outputs 0, no response, and cmd_ready = 1 after release.
